// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller is the master: it reads decode fields/flags and drives every select.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, memready,
        output pcen, iord, memwrite, irwrite, regdst, memtoreg,
        output regwrite, alusrca, alusrcb, pcsrc, alucontrol, state
    );

    modport slave (
        output op, funct, zero, memready,
        input  pcen, iord, memwrite, irwrite, regdst, memtoreg,
        input  regwrite, alusrca, alusrcb, pcsrc, alucontrol, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences the shared ALU, memory port and
// register file over 3-5 cycles per instruction, stalling on memready.
module multicycle_controller #(
    parameter bit ADDI_EN = 1'b1,
    parameter bit JUMP_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state_q;
    state_t     state_d;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = S_FETCH;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        aluop        = 2'b00;
        bus.iord     = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;

        case (state_q)
            S_FETCH: begin
                bus.alusrcb = 2'b01;
                bus.irwrite = bus.memready;
                pcwrite     = bus.memready;
                state_d     = bus.memready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = ADDI_EN ? S_ADDIEX : S_FETCH;
                    OP_J:         state_d = JUMP_EN ? S_JUMP : S_FETCH;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_d     = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                state_d  = bus.memready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                state_d      = bus.memready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                bus.alusrca = 1'b1;
                aluop       = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                aluop       = 2'b01;
                bus.pcsrc   = 2'b01;
                branch      = 1'b1;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.regwrite = 1'b1;
            end
            S_JUMP: begin
                bus.pcsrc = 2'b10;
                pcwrite   = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A write in the reset cycle must never land, whatever state we were in.
        if (reset) begin
            bus.memwrite = 1'b0;
            bus.irwrite  = 1'b0;
            bus.regwrite = 1'b0;
            pcwrite      = 1'b0;
            branch       = 1'b0;
        end
    end

    assign bus.pcen  = pcwrite | (branch & bus.zero);
    assign bus.state = state_q;

    always_comb begin
        bus.alucontrol = 3'b010;
        case (aluop)
            2'b01: bus.alucontrol = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = 3'b010;
                endcase
            end
            default: bus.alucontrol = 3'b010;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level reference model with
// directed and randomized instruction streams and memready stalls.
module tb_multicycle_controller;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    multicycle_controller_if if1 ();
    multicycle_controller_if if2 ();

    multicycle_controller #(.ADDI_EN(1'b1), .JUMP_EN(1'b1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    multicycle_controller #(.ADDI_EN(1'b0), .JUMP_EN(1'b0)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    // Expected outputs for a state, packed as
    // {state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
    //  alusrca, alusrcb, pcsrc, alucontrol}
    function automatic logic [18:0] expect_word(input int st, input logic mr,
                                                input logic [5:0] funct,
                                                input logic zero);
        logic pcen, iord, mw, irw, rdst, m2r, rw, asa;
        logic [1:0] asb, psrc;
        logic [2:0] ac;
        {pcen, iord, mw, irw, rdst, m2r, rw, asa} = 8'b0;
        asb  = 2'b00;
        psrc = 2'b00;
        ac   = 3'b010;
        case (st)
            0:  begin pcen = mr; irw = mr; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  iord = 1'b1;
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin iord = 1'b1; mw = 1'b1; end
            6:  begin
                    asa = 1'b1;
                    if (funct == 6'b100010) ac = 3'b110;
                    else if (funct == 6'b100100) ac = 3'b000;
                    else if (funct == 6'b100101) ac = 3'b001;
                    else if (funct == 6'b101010) ac = 3'b111;
                    else ac = 3'b010;
                end
            7:  begin rdst = 1'b1; rw = 1'b1; end
            8:  begin asa = 1'b1; psrc = 2'b01; ac = 3'b110; pcen = zero; end
            9:  begin asa = 1'b1; asb = 2'b10; end
            10: rw = 1'b1;
            11: begin psrc = 2'b10; pcen = 1'b1; end
            default: ;
        endcase
        return {st[3:0], pcen, iord, mw, irw, rdst, m2r, rw, asa, asb, psrc, ac};
    endfunction

    task automatic check(input string tag, input bit sel, input logic [18:0] exp);
        logic [18:0] obs;
        if (sel)
            obs = {if2.state, if2.pcen, if2.iord, if2.memwrite, if2.irwrite,
                   if2.regdst, if2.memtoreg, if2.regwrite, if2.alusrca,
                   if2.alusrcb, if2.pcsrc, if2.alucontrol};
        else
            obs = {if1.state, if1.pcen, if1.iord, if1.memwrite, if1.irwrite,
                   if1.regdst, if1.memtoreg, if1.regwrite, if1.alusrca,
                   if1.alusrcb, if1.pcsrc, if1.alucontrol};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
        total++;
        assert ($countones({obs[12], obs[11], obs[9]}) <= 1) else begin
            bad++;
            $error("FAIL %s_strobes obs=%b exp=at_most_one", tag,
                   {obs[12], obs[11], obs[9]});
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] funct,
                         input logic zero, input logic mr);
        if1.op = op;       if2.op = op;
        if1.funct = funct; if2.funct = funct;
        if1.zero = zero;   if2.zero = zero;
        if1.memready = mr; if2.memready = mr;
    endtask

    // Run one instruction from FETCH. fs/ms: memready-low cycles in FETCH and
    // in MEMRD/MEMWR. abort_at >= 0 asserts reset during that path step.
    task automatic run_instr(input string tag, input logic [5:0] op,
                             input logic [5:0] funct, input logic zero,
                             input int fs, input int ms, input bit sel,
                             input int abort_at);
        int p[$];
        bit addi_en, jump_en;
        addi_en = !sel;
        jump_en = !sel;
        p = {0, 1};
        if (op == 6'b100011) p = {0, 1, 2, 3, 4};
        else if (op == 6'b101011) p = {0, 1, 2, 5};
        else if (op == 6'b000000) p = {0, 1, 6, 7};
        else if (op == 6'b000100) p = {0, 1, 8};
        else if (op == 6'b001000 && addi_en) p = {0, 1, 9, 10};
        else if (op == 6'b000010 && jump_en) p = {0, 1, 11};
        for (int i = 0; i < p.size(); i++) begin
            int st;
            int stalls;
            logic mr;
            st = p[i];
            if (i == abort_at) begin
                drive(op, funct, zero, 1'b1);
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            stalls = (st == 0) ? fs : ((st == 3 || st == 5) ? ms : 0);
            for (int k = 0; k <= stalls; k++) begin
                if (st == 0 || st == 3 || st == 5) mr = (k == stalls);
                else mr = 1'($urandom);
                drive(op, funct, zero, mr);
                @(negedge clk);
                check(tag, sel, expect_word(st, mr, funct, zero));
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(6'd0, 6'd0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [5:0] ops [0:6];
        logic [5:0] fns [0:6];
        total = 0;
        bad   = 0;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b101010, 6'b000111, 6'b111111};

        do_reset();
        run_instr("lw",       6'b100011, 6'd0,      1'b0, 0, 0, 0, -1);
        run_instr("sw_stall", 6'b101011, 6'd0,      1'b0, 0, 3, 0, -1);
        run_instr("r_slt",    6'b000000, 6'b101010, 1'b0, 0, 0, 0, -1);
        run_instr("r_sub",    6'b000000, 6'b100010, 1'b0, 0, 0, 0, -1);
        run_instr("r_unk",    6'b000000, 6'b000111, 1'b1, 0, 0, 0, -1);
        run_instr("beq_z1",   6'b000100, 6'd0,      1'b1, 0, 0, 0, -1);
        run_instr("beq_z0",   6'b000100, 6'd0,      1'b0, 0, 0, 0, -1);
        run_instr("j",        6'b000010, 6'd0,      1'b0, 0, 0, 0, -1);
        run_instr("addi",     6'b001000, 6'd0,      1'b0, 0, 0, 0, -1);
        run_instr("illegal",  6'b111111, 6'd0,      1'b0, 0, 0, 0, -1);
        run_instr("lw_stall", 6'b100011, 6'd0,      1'b0, 2, 1, 0, -1);
        run_instr("lw_abort", 6'b100011, 6'd0,      1'b0, 0, 0, 0, 4);
        run_instr("post_rst", 6'b000000, 6'b100101, 1'b0, 0, 0, 0, -1);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 6)];
            if (op == 6'b111111) op = 6'($urandom);
            fn = fns[$urandom_range(0, 6)];
            run_instr("rand", op, fn, 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), 0, -1);
        end

        do_reset();
        run_instr("noaddi", 6'b001000, 6'd0, 1'b0, 0, 0, 1, -1);
        run_instr("noj",    6'b000010, 6'd0, 1'b0, 1, 0, 1, -1);
        run_instr("lw_en0", 6'b100011, 6'd0, 1'b0, 0, 2, 1, -1);
        do_reset();
        run_instr("final",  6'b101011, 6'd0, 1'b0, 0, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
